// File: rtl/flow_sched_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : flow_sched_pkg                                            |
// | Desc     : Shared types and demand-nibble helpers for flow_scheduler |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package flow_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWITCH = 2'd1,
        S_SERVE  = 2'd2
    } state_t;

    typedef struct packed {
        logic fr2;
        logic fr1;
        logic fr0;
        logic dfr;
    } demand_t;

    localparam int c_NIB_W = 4;

    function automatic logic is_req(input demand_t d);
        return d.fr2 | d.fr1 | d.fr0;
    endfunction

    function automatic logic is_urgent(input demand_t d);
        return d.fr2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flow_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | Module   : flow_rr_arbiter                                           |
// | Desc     : Combinational round-robin picker, urgent requests first   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module flow_rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [N_CH-1:0]  urgent,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_p;
    logic             w_u_found;
    logic             w_r_found;
    logic [IDX_W-1:0] w_u_idx;
    logic [IDX_W-1:0] w_r_idx;

    // Search order is last+1, last+2, ... wrapping, so 'last' itself is checked last.
    always_comb begin
        w_p       = '0;
        w_u_found = 1'b0;
        w_r_found = 1'b0;
        w_u_idx   = '0;
        w_r_idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            w_p = IDX_W'((int'(last) + k) % N_CH);
            if (!w_u_found && urgent[w_p]) begin
                w_u_found = 1'b1;
                w_u_idx   = w_p;
            end
            if (!w_r_found && req[w_p]) begin
                w_r_found = 1'b1;
                w_r_idx   = w_p;
            end
        end
        found = w_u_found | w_r_found;
        idx   = w_u_found ? w_u_idx : w_r_idx;
    end

endmodule

`default_nettype wire

// File: rtl/flow_scheduler.sv
// +----------------------------------------------------------------------+
// | Module   : flow_scheduler                                            |
// | Desc     : Shares one supply pump among N_CH reservoir valves.       |
// |            Define FLOW_SCHED_PREEMPT_EN to let urgent channels       |
// |            preempt a non-urgent one after MIN_DWELL.                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module flow_scheduler
    import flow_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int SWITCH_CYC = 2,
    parameter int MIN_DWELL  = 8,
    parameter int MAX_DWELL  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [4*N_CH-1:0]        demand,
    output logic [N_CH-1:0]          valve_oh,
    output logic [2:0]               pump_fr,
    output logic                     pump_dfr,
    output logic [$clog2(N_CH)-1:0]  grant_id,
    output logic                     busy
);

    localparam int c_IDX_W   = $clog2(N_CH);
    localparam int c_DWELL_W = $clog2(MAX_DWELL + 1);
    localparam logic [c_DWELL_W-1:0] c_DWELL_MAX = c_DWELL_W'(MAX_DWELL);
    localparam logic [c_DWELL_W-1:0] c_DWELL_MIN = c_DWELL_W'(MIN_DWELL);
    localparam logic [3:0]           c_SW_LAST   = 4'(SWITCH_CYC - 1);

    state_t                 r_state, w_next_state;
    logic [c_IDX_W-1:0]     r_grant, w_next_grant;
    logic [c_DWELL_W-1:0]   r_dwell, w_next_dwell;
    logic [3:0]             r_sw_cnt, w_next_sw_cnt;

    demand_t                w_nib [N_CH];
    demand_t                w_gnib;
    logic [N_CH-1:0]        w_req;
    logic [N_CH-1:0]        w_urg;
    logic [N_CH-1:0]        w_gmask;
    logic                   w_arb_found;
    logic [c_IDX_W-1:0]     w_arb_idx;
    logic                   w_min_met;
    logic                   w_release;
    logic                   w_rotate;
    logic                   w_preempt;
    logic                   w_arbitrate;

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_nib[i] = demand_t'(demand[c_NIB_W*i +: c_NIB_W]);
            assign w_req[i] = is_req(w_nib[i]);
            assign w_urg[i] = is_urgent(w_nib[i]);
        end
    endgenerate

    assign w_gmask   = {{(N_CH-1){1'b0}}, 1'b1} << r_grant;
    assign w_gnib    = w_nib[r_grant];
    assign w_min_met = (r_dwell >= c_DWELL_MIN);
    assign w_release = !w_req[r_grant] && w_min_met;
    assign w_rotate  = (r_dwell == c_DWELL_MAX) && (|(w_req & ~w_gmask));

`ifdef FLOW_SCHED_PREEMPT_EN
    logic w_other_urg;
    assign w_other_urg = |(w_urg & ~w_gmask);
    assign w_preempt   = !w_urg[r_grant] && w_other_urg && w_min_met;
`else
    assign w_preempt   = 1'b0;
`endif

    assign w_arbitrate = w_release || w_rotate || w_preempt;

    flow_rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .req    (w_req),
        .urgent (w_urg),
        .last   (r_grant),
        .found  (w_arb_found),
        .idx    (w_arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= c_IDX_W'(N_CH - 1);
            r_dwell  <= '0;
            r_sw_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_grant  <= w_next_grant;
            r_dwell  <= w_next_dwell;
            r_sw_cnt <= w_next_sw_cnt;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_grant  = r_grant;
        w_next_dwell  = '0;
        w_next_sw_cnt = r_sw_cnt;
        valve_oh      = '0;
        pump_fr       = 3'b000;
        pump_dfr      = 1'b0;
        busy          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (enable && w_arb_found) begin
                    w_next_state  = S_SWITCH;
                    w_next_grant  = w_arb_idx;
                    w_next_sw_cnt = '0;
                end
            end
            S_SWITCH: begin
                valve_oh = w_gmask;
                busy     = 1'b1;
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (r_sw_cnt == c_SW_LAST) begin
                    w_next_state = S_SERVE;
                end else begin
                    w_next_sw_cnt = r_sw_cnt + 1'b1;
                end
            end
            S_SERVE: begin
                valve_oh = w_gmask;
                busy     = 1'b1;
                pump_fr  = {w_gnib.fr2, w_gnib.fr1, w_gnib.fr0};
                pump_dfr = w_gnib.dfr;
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (w_arbitrate) begin
                    // Re-winning the same channel keeps the valve open; only dwell restarts.
                    if (!w_arb_found) begin
                        w_next_state = S_IDLE;
                    end else if (w_arb_idx != r_grant) begin
                        w_next_state  = S_SWITCH;
                        w_next_grant  = w_arb_idx;
                        w_next_sw_cnt = '0;
                    end
                end else begin
                    w_next_dwell = (r_dwell == c_DWELL_MAX) ? r_dwell : r_dwell + 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign grant_id = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_flow_scheduler.sv
// +----------------------------------------------------------------------+
// | Module   : tb_flow_scheduler                                         |
// | Desc     : Vector table, directed sequences and random run vs model  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_flow_scheduler;

    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int MIN_D = 8;
    localparam int MAX_D = 64;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] demand = 16'h0000;
    logic [3:0]  valve_oh;
    logic [2:0]  pump_fr;
    logic        pump_dfr;
    logic [1:0]  grant_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model: valve open/closed, pump-off cycles still to go, dwell, owner.
    bit m_open    = 1'b0;
    int m_sw_left = 0;
    int m_dwell   = 0;
    int m_grant   = N - 1;

    typedef struct {
        bit          rst;
        bit          en;
        logic [15:0] dem;
        logic [3:0]  valve;
        logic [2:0]  fr;
        bit          dfr;
        bit          bsy;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl [13];

    flow_scheduler #(
        .N_CH       (N),
        .SWITCH_CYC (SW),
        .MIN_DWELL  (MIN_D),
        .MAX_DWELL  (MAX_D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .demand   (demand),
        .valve_oh (valve_oh),
        .pump_fr  (pump_fr),
        .pump_dfr (pump_dfr),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] nib(input logic [15:0] d, input int c);
        return d[4*c +: 4];
    endfunction

    function automatic int pick(input logic [15:0] d, input int last);
        int p;
        int c;
        logic [3:0] nb;
        p = -1;
        for (int k = 1; k <= N; k++) begin
            c  = (last + k) % N;
            nb = nib(d, c);
            if (p < 0 && nb[3]) p = c;
        end
        for (int k = 1; k <= N; k++) begin
            c  = (last + k) % N;
            nb = nib(d, c);
            if (p < 0 && nb[3:1] != 3'b000) p = c;
        end
        return p;
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [15:0] d);
        int p;
        bit go;
        bit g_req;
        bit g_urg;
        bit o_req;
        bit o_urg;
        logic [3:0] nb;
        if (r) begin
            m_open = 0; m_sw_left = 0; m_dwell = 0; m_grant = N - 1;
        end else if (!m_open) begin
            p = pick(d, m_grant);
            if (e && p >= 0) begin
                m_open = 1; m_grant = p; m_sw_left = SW;
            end
        end else if (!e) begin
            m_open = 0; m_sw_left = 0; m_dwell = 0;
        end else if (m_sw_left > 0) begin
            m_sw_left = m_sw_left - 1;
            m_dwell   = 0;
        end else begin
            nb    = nib(d, m_grant);
            g_req = (nb[3:1] != 3'b000);
            g_urg = nb[3];
            o_req = 0;
            o_urg = 0;
            for (int c = 0; c < N; c++) begin
                nb = nib(d, c);
                if (c != m_grant && nb[3:1] != 3'b000) o_req = 1;
                if (c != m_grant && nb[3]) o_urg = 1;
            end
            go = (!g_req && m_dwell >= MIN_D) || (m_dwell == MAX_D && o_req);
`ifdef FLOW_SCHED_PREEMPT_EN
            go = go || (!g_urg && o_urg && m_dwell >= MIN_D);
`else
            if (g_urg && o_urg) go = go;
`endif
            if (go) begin
                p = pick(d, m_grant);
                m_dwell = 0;
                if (p < 0) begin
                    m_open = 0;
                end else if (p != m_grant) begin
                    m_grant = p; m_sw_left = SW;
                end
            end else begin
                m_dwell = (m_dwell + 1 > MAX_D) ? MAX_D : m_dwell + 1;
            end
        end
    endtask

    function automatic logic [31:0] model_vec(input logic [15:0] d);
        logic [3:0] nb;
        logic [3:0] v;
        bit serving;
        nb      = nib(d, m_grant);
        v       = m_open ? (4'b0001 << m_grant) : 4'b0000;
        serving = m_open && (m_sw_left == 0);
        return {21'd0, v, serving ? nb[3:1] : 3'b000, serving ? nb[0] : 1'b0,
                m_open, 2'(m_grant)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {21'd0, valve_oh, pump_fr, pump_dfr, busy, grant_id};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit r, input bit e, input logic [15:0] d);
        reset  = r;
        enable = e;
        demand = d;
        @(posedge clk);
        model_step(r, e, d);
        #1;
        check("model", dut_vec(), model_vec(d));
    endtask

    // Counts consecutive observations matching valve v and pump on/off, ticking with demand d.
    task automatic count_while(input logic [15:0] d, input logic [3:0] v, input bit on,
                               output int n);
        n = 0;
        while (valve_oh == v && ((pump_fr != 3'b000) == on) && n < 300) begin
            n++;
            tick(1'b0, 1'b1, d);
        end
    endtask

    task automatic wait_pump(input logic [15:0] d);
        int n;
        n = 0;
        while (pump_fr == 3'b000 && n < 10) begin
            n++;
            tick(1'b0, 1'b1, d);
        end
        check("wait_pump", 32'(pump_fr != 3'b000), 32'd1);
    endtask

    initial begin
        int n;
        bit e;
        bit r;
        int ch;
        logic [15:0] d;
        logic [3:0] nv;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3};
        tbl[1]  = '{1'b0, 1'b1, 16'h0600, 4'b0100, 3'b000, 1'b0, 1'b1, 2'd2};
        tbl[2]  = '{1'b0, 1'b1, 16'h0600, 4'b0100, 3'b000, 1'b0, 1'b1, 2'd2};
        tbl[3]  = '{1'b0, 1'b1, 16'h0600, 4'b0100, 3'b011, 1'b0, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 1'b1, 16'h0600, 4'b0100, 3'b011, 1'b0, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 1'b1, 16'h0F00, 4'b0100, 3'b111, 1'b1, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 1'b0, 16'h0F00, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd2};
        tbl[7]  = '{1'b0, 1'b0, 16'h0202, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd2};
        tbl[8]  = '{1'b0, 1'b1, 16'h0202, 4'b0001, 3'b000, 1'b0, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 1'b1, 16'h0202, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3};
        tbl[10] = '{1'b0, 1'b1, 16'h2222, 4'b0001, 3'b000, 1'b0, 1'b1, 2'd0};
        tbl[11] = '{1'b1, 1'b1, 16'h0000, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3};
        tbl[12] = '{1'b0, 1'b1, 16'h8222, 4'b1000, 3'b000, 1'b0, 1'b1, 2'd3};

        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].dem);
            check($sformatf("vec%0d", i), dut_vec(),
                  {21'd0, tbl[i].valve, tbl[i].fr, tbl[i].dfr, tbl[i].bsy, tbl[i].gid});
        end

        // Release: demand drops at dwell 3, valve stays open through dwell MIN_D.
        tick(1'b1, 1'b0, 16'h0000);
        wait_pump(16'h0600);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 16'h0600);
        tick(1'b0, 1'b1, 16'h0000);
        n = 0;
        while (valve_oh == 4'b0100 && n < 20) begin
            n++;
            tick(1'b0, 1'b1, 16'h0000);
        end
        check("release_hold", 32'(n), 32'(MIN_D - 3));
        check("release_idle", {30'd0, busy, |valve_oh}, 32'd0);

        // Rotation: dwell values 0..MAX_D are all served before handing over.
        tick(1'b1, 1'b0, 16'h0000);
        wait_pump(16'h0022);
        check("rot_first", 32'(valve_oh), 32'h1);
        count_while(16'h0022, 4'b0001, 1'b1, n);
        check("rot_ch0_serve", 32'(n), 32'(MAX_D + 1));
        count_while(16'h0022, 4'b0010, 1'b0, n);
        check("rot_gap", 32'(n), 32'(SW));
        check("rot_ch1_pump", 32'(pump_fr), 32'h1);
        count_while(16'h0022, 4'b0010, 1'b1, n);
        check("rot_ch1_serve", 32'(n), 32'(MAX_D + 1));
        check("rot_back_ch0", 32'(valve_oh), 32'h1);

        // Urgency: ch3 goes urgent while ch1 serves at dwell 2.
        tick(1'b1, 1'b0, 16'h0000);
        wait_pump(16'h0020);
        tick(1'b0, 1'b1, 16'h0020);
        tick(1'b0, 1'b1, 16'h0020);
        count_while(16'hF020, 4'b0010, 1'b1, n);
`ifdef FLOW_SCHED_PREEMPT_EN
        check("urgent_hold", 32'(n), 32'(MIN_D - 1));
`else
        check("urgent_hold", 32'(n), 32'(MAX_D - 1));
`endif
        check("urgent_valve", 32'(valve_oh), 32'h8);

        // Reset while serving, then channel 0 wins with everyone requesting.
        wait_pump(16'hF020);
        tick(1'b1, 1'b1, 16'h2222);
        check("reset_mid", dut_vec(), {21'd0, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3});
        tick(1'b0, 1'b1, 16'h2222);
        check("reset_first", dut_vec(), {21'd0, 4'b0001, 3'b000, 1'b0, 1'b1, 2'd0});

        // Random traffic against the model.
        tick(1'b1, 1'b0, 16'h0000);
        d = 16'h0000;
        e = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) begin
                ch = int'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       nv = 4'h0;
                    1:       nv = 4'h2;
                    default: nv = 4'($urandom);
                endcase
                d[4*ch +: 4] = nv;
            end
            if (e && $urandom_range(0, 149) == 0) e = 1'b0;
            else if (!e && $urandom_range(0, 3) == 0) e = 1'b1;
            r = ($urandom_range(0, 599) == 0);
            tick(r, e, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
